// File: rtl/gate_bist_ctrl_if.sv
// Signal bundle between the gate BIST sequencer and its surroundings.
// master: the requester / gate side (drives start and the gate output).
// slave:  the sequencer itself.
interface gate_bist_if;
  logic       start;
  logic       gate_a;
  logic       gate_b;
  logic       gate_y;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_mask;
  logic [1:0] first_fail;

  modport master (
    output start, gate_y,
    input  gate_a, gate_b, busy, done, pass, fail_mask, first_fail
  );

  modport slave (
    input  start, gate_y,
    output gate_a, gate_b, busy, done, pass, fail_mask, first_fail
  );
endinterface

// File: rtl/gate_bist_ctrl.sv
// Built-in self-test sequencer for a 2-input logic gate. Walks {a,b}
// through 00,01,10,11, lets each vector settle, samples the gate output
// once per vector and reports pass / per-vector failure mask.
module gate_bist_ctrl #(
  parameter logic [3:0] TRUTH  = 4'b0111,
  parameter int         SETTLE = 2
) (
  input logic       clk,
  input logic       rst,
  gate_bist_if.slave bus
);

  if (SETTLE < 1 || SETTLE > 15) begin : g_settle_range
    $error("gate_bist_ctrl: SETTLE must be in 1..15");
  end

  localparam int            CW       = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, FINISH} state_t;

  state_t        state_q;
  logic [1:0]    vec_q;
  logic [CW-1:0] cnt_q;
  logic          gate_a_q;
  logic          gate_b_q;
  logic          busy_q;
  logic          done_q;
  logic          pass_q;
  logic [3:0]    fail_mask_q;
  logic [1:0]    first_fail_q;

  logic [3:0]    fail_mask_d;
  logic [1:0]    vec_d;

  // Lowest set bit index of the failure mask; 0 when the mask is empty.
  function automatic logic [1:0] lowest_fail(input logic [3:0] m);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Mask including the vector being sampled this cycle (gate_y only matters in SAMPLE).
  always_comb begin
    fail_mask_d = fail_mask_q;
    vec_d       = vec_q + 2'd1;
    if (state_q == SAMPLE && bus.gate_y != TRUTH[vec_q]) begin
      fail_mask_d[vec_q] = 1'b1;
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      vec_q        <= 2'd0;
      cnt_q        <= '0;
      gate_a_q     <= 1'b0;
      gate_b_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_mask_q  <= 4'd0;
      first_fail_q <= 2'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q      <= WAIT;
            vec_q        <= 2'd0;
            cnt_q        <= '0;
            gate_a_q     <= 1'b0;
            gate_b_q     <= 1'b0;
            busy_q       <= 1'b1;
            pass_q       <= 1'b0;
            fail_mask_q  <= 4'd0;
            first_fail_q <= 2'd0;
          end
        end
        WAIT: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= SAMPLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        SAMPLE: begin
          fail_mask_q <= fail_mask_d;
          if (vec_q == 2'd3) begin
            // Results are taken from the updated mask so vector 3 counts.
            state_q      <= FINISH;
            gate_a_q     <= 1'b0;
            gate_b_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            pass_q       <= ~|fail_mask_d;
            first_fail_q <= lowest_fail(fail_mask_d);
          end else begin
            state_q  <= WAIT;
            vec_q    <= vec_d;
            gate_a_q <= vec_d[1];
            gate_b_q <= vec_d[0];
          end
        end
        FINISH: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.gate_a     = gate_a_q;
  assign bus.gate_b     = gate_b_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.fail_mask  = fail_mask_q;
  assign bus.first_fail = first_fail_q;

endmodule

// File: doc/gate_bist_ctrl.md
# gate_bist_ctrl

Built-in self-test sequencer for a 2-input combinational logic gate (NAND, AND, OR, XOR and so on).
- On a start request it drives the gate's `a`/`b` inputs through all four input combinations, waits a fixed settle time per vector and samples the gate output.
- It compares each sample against a parameterised truth table and reports pass/fail with a per-vector failure mask.
- It sits beside any gate cell in the basic-logic library as its on-chip checker.

## Interface
Parameters:
- `TRUTH`, default 4'b0111: expected output per vector. Bit index = {a,b}. The default is the NAND truth table.
- `SETTLE`, default 2: wait cycles per vector before the sample cycle. Legal range 1..15; values outside it are an elaboration error.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  run request; sampled only in IDLE.
- `gate_a`  out  1  drive to the gate's `a` input.
- `gate_b`  out  1  drive to the gate's `b` input.
- `gate_y`  in  1  gate output under test.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  one-cycle pulse at the end of a run.
- `pass`  out  1  1 when the last run had no mismatches.
- `fail_mask`  out  4  bit i set when vector i mismatched in the last run.
- `first_fail`  out  2  lowest failing vector index of the last run; 0 if none failed.

## Operation
- State machine: IDLE, WAIT, SAMPLE, FINISH.
- Vector counter `vec` is 2 bits, stepping 0,1,2,3. `gate_a` = `vec[1]`, `gate_b` = `vec[0]` whenever `busy` is high.
- Settle counter width is $clog2(SETTLE+1).

State transitions:
- IDLE: `gate_a`/`gate_b` = 0 and `busy` = 0.
  - `start`=1 moves to WAIT with `vec` = 0 and settle count cleared.
  - The same edge clears `fail_mask`, `first_fail` and `pass`.
- WAIT: counts SETTLE cycles, then moves to SAMPLE.
- SAMPLE: one cycle. At its closing edge `gate_y` is compared with `TRUTH[vec]`; a mismatch sets `fail_mask[vec]`.
  - If `vec` < 3: increment `vec` and return to WAIT.
  - If `vec` = 3: move to FINISH.
- FINISH: one cycle.
  - `done` = 1 and `busy` = 0.
  - `pass` = ~|`fail_mask` (including any vector 3 failure).
  - `first_fail` = lowest set bit index of `fail_mask`, 0 if the mask is empty.
  - Next state is IDLE.

Result and request rules:
- Results hold in IDLE until the next accepted `start` or `rst`.
- `start` is ignored outside IDLE; there is no queueing.
- `start` held high continuously starts a new run on every IDLE cycle, i.e. back-to-back runs with one IDLE cycle between them.
- `gate_y` is ignored outside SAMPLE.

Reset:
- `rst` high at any edge, including mid-run, forces IDLE.
- From the following cycle all outputs are 0: `gate_a`, `gate_b`, `busy`, `done`, `pass`, `fail_mask`, `first_fail`.
- `rst` has priority over `start` on the same edge.

## Timing
- `start` accepted at edge E0.
  - `busy` = 1 and vector 0 on `gate_a`/`gate_b` from the cycle after E0.
- Each vector is held SETTLE+1 cycles.
  - Vector k is sampled at edge E0+(k+1)(SETTLE+1).
  - The next vector appears on the outputs the cycle after that edge.
- `done` is high in the cycle after edge E0+4(SETTLE+1); `busy` is low in that same cycle.
  - `pass`, `fail_mask` and `first_fail` are valid in that cycle and stay stable afterwards.
  - With SETTLE=2, vectors are sampled at E0+3, +6, +9, +12 and `done` is high after E0+12.
- `gate_a`/`gate_b` change only on vector boundaries, never inside the settle window. They are registered outputs with no combinational path from `gate_y`.
- Minimum run-to-run spacing: 4(SETTLE+1)+2 cycles (FINISH plus one IDLE cycle).

## Test plan
- Correct NAND gate, defaults, `start` pulse at E0 -> `gate_a`/`gate_b` sequence 00,01,10,11 with 3 cycles each; `done` pulse after E0+12; `pass`=1, `fail_mask`=0000, `first_fail`=0.
- NAND with output stuck at 1 -> `pass`=0, `fail_mask`=1000, `first_fail`=3.
- AND gate checked with TRUTH=0111 -> `fail_mask`=1111, `first_fail`=0; then a second run on a correct NAND -> `fail_mask` clears to 0000 and `pass`=1.
- `start` pulsed at E0+5 during a run -> ignored; exactly one `done` pulse; `start` held high -> successive `done` pulses 14 cycles apart at SETTLE=2.
- `rst` asserted at E0+7 (vector 2 settling) -> from the next cycle `busy`/`gate_a`/`gate_b`/`pass`/`fail_mask`=0 and no `done`; a fresh `start` then completes normally.
- SETTLE=1 with `gate_y` glitching wrong only during WAIT cycles -> no failure recorded; `done` high after E0+8.
